// File: rtl/pe_array_ctrl.sv
// pe_array_ctrl: sequencing controller for a weight-stationary ROWS x COLS
// systolic PE array. One job per start: it loads COLS weight beats, streams N
// activation vectors with per-row input skew, and returns one column-aligned
// psum vector per input vector.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   start, cfg_num_vecs,
//   cfg_quantize                job launch and configuration, latched at start
//   busy, done                  job status (done is a one-cycle pulse)
//   w_valid/w_ready/w_data      weight stream, one beat per array column
//   a_valid/a_ready/a_data      activation vector stream
//   r_valid/r_ready/r_data      aligned result stream
//   arr_*                       array control, data and psum pins
module pe_array_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [CNT_WIDTH-1:0]       cfg_num_vecs,
  input  logic                       cfg_quantize,
  output logic                       busy,
  output logic                       done,
  input  logic                       w_valid,
  output logic                       w_ready,
  input  logic [DATA_WIDTH*ROWS-1:0] w_data,
  input  logic                       a_valid,
  output logic                       a_ready,
  input  logic [DATA_WIDTH*ROWS-1:0] a_data,
  output logic                       r_valid,
  input  logic                       r_ready,
  output logic [ACC_WIDTH*COLS-1:0]  r_data,
  output logic                       arr_enable,
  output logic                       arr_load_weight,
  output logic                       arr_quantize_mode,
  output logic [DATA_WIDTH*ROWS-1:0] arr_act_flat,
  output logic [DATA_WIDTH*ROWS-1:0] arr_weight_flat,
  output logic [ACC_WIDTH*COLS-1:0]  arr_psum_in_flat,
  input  logic [ACC_WIDTH*COLS-1:0]  arr_psum_out_flat
);

  // A vector's tag exits exactly when its last column's psum is aligned.
  localparam int TAG_LEN = ROWS + COLS - 1;

  typedef enum logic [2:0] {IDLE, LOAD_W, COMPUTE, DRAIN, DONE} state_t;

  state_t                      state, state_next;
  logic [CNT_WIDTH-1:0]        n_q, beat_cnt, res_cnt;
  logic                        quant_q;
  logic [TAG_LEN-1:0]          tag_q;
  logic                        r_valid_q;
  logic [ACC_WIDTH*COLS-1:0]   r_data_q;
  logic                        step, out_free, w_fire, r_fire, capture, tag_in;
  logic [DATA_WIDTH*ROWS-1:0]  skew_in, skew_out;
  logic [ACC_WIDTH*COLS-1:0]   aligned;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next        = state;
    busy              = (state != IDLE);
    done              = (state == DONE);
    out_free          = !r_valid_q || r_ready;
    r_fire            = r_valid_q && r_ready;
    w_ready           = (state == LOAD_W);
    w_fire            = w_ready && w_valid;
    a_ready           = (state == COMPUTE) && out_free;
    step              = 1'b0;
    tag_in            = (state == COMPUTE);
    skew_in           = (state == COMPUTE) ? a_data : '0;
    arr_load_weight   = w_fire;
    arr_weight_flat   = w_fire ? w_data : '0;
    arr_act_flat      = (state == COMPUTE || state == DRAIN) ? skew_out : '0;
    arr_quantize_mode = quant_q && (state != IDLE);
    arr_psum_in_flat  = '0;
    case (state)
      IDLE: begin
        if (start) state_next = (cfg_num_vecs == '0) ? DONE : LOAD_W;
      end
      LOAD_W: begin
        if (w_fire && beat_cnt == CNT_WIDTH'(COLS - 1)) state_next = COMPUTE;
      end
      COMPUTE: begin
        step = out_free && a_valid;
        if (step && beat_cnt == n_q - CNT_WIDTH'(1)) state_next = DRAIN;
      end
      DRAIN: begin
        step = out_free;
        if (r_fire && res_cnt == n_q - CNT_WIDTH'(1)) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    arr_enable = step;
    capture    = step && tag_q[TAG_LEN-1];
  end

  assign r_valid = r_valid_q;
  assign r_data  = r_data_q;

  // beat_cnt counts weight beats in LOAD_W, then accepted vectors in COMPUTE.
  always_ff @(posedge clk) begin
    if (rst) begin
      n_q      <= '0;
      quant_q  <= 1'b0;
      beat_cnt <= '0;
      res_cnt  <= '0;
    end else begin
      if (state == IDLE && start) begin
        n_q      <= cfg_num_vecs;
        quant_q  <= cfg_quantize;
        beat_cnt <= '0;
        res_cnt  <= '0;
      end
      if (w_fire)
        beat_cnt <= (beat_cnt == CNT_WIDTH'(COLS - 1)) ? '0 : beat_cnt + CNT_WIDTH'(1);
      if (step && state == COMPUTE)
        beat_cnt <= beat_cnt + CNT_WIDTH'(1);
      if (r_fire)
        res_cnt <= res_cnt + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q     <= '0;
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
    end else begin
      if (step) tag_q <= {tag_q[TAG_LEN-2:0], tag_in};
      if (capture) begin
        r_valid_q <= 1'b1;
        r_data_q  <= aligned;
      end else if (r_fire) begin
        r_valid_q <= 1'b0;
      end
    end
  end

  // Input skew: row i is delayed by i steps; row 0 goes straight through.
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_skew
    if (gi == 0) begin : g_pass
      assign skew_out[0 +: DATA_WIDTH] = skew_in[0 +: DATA_WIDTH];
    end else begin : g_dly
      logic [DATA_WIDTH-1:0] dly [gi];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int unsigned k = 0; k < gi; k++) dly[k] <= '0;
        end else if (step) begin
          dly[0] <= skew_in[gi*DATA_WIDTH +: DATA_WIDTH];
          for (int unsigned k = 1; k < gi; k++) dly[k] <= dly[k-1];
        end
      end
      assign skew_out[gi*DATA_WIDTH +: DATA_WIDTH] = dly[gi-1];
    end
  end

  // Output deskew: column j waits COLS-1-j steps so all columns line up with
  // the last column, which is used directly.
  for (genvar gj = 0; gj < COLS; gj++) begin : g_deskew
    localparam int D = COLS - 1 - gj;
    if (D == 0) begin : g_pass
      assign aligned[gj*ACC_WIDTH +: ACC_WIDTH] = arr_psum_out_flat[gj*ACC_WIDTH +: ACC_WIDTH];
    end else begin : g_dly
      logic [ACC_WIDTH-1:0] dly [D];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int unsigned k = 0; k < D; k++) dly[k] <= '0;
        end else if (step) begin
          dly[0] <= arr_psum_out_flat[gj*ACC_WIDTH +: ACC_WIDTH];
          for (int unsigned k = 1; k < D; k++) dly[k] <= dly[k-1];
        end
      end
      assign aligned[gj*ACC_WIDTH +: ACC_WIDTH] = dly[D-1];
    end
  end

endmodule
